rf_wb_arbiter: RTL and testbench
================================

// Module: rf_wb_arbiter
// PURPOSE
//  Shares the register file's single write port (we3/a3/wd3) between NREQ writeback sources: ALU, load, multiply.
//  Writes with address 15 are steered to the PC write port, because the register file holds only r0-r14.
//  Keeps a pending-write scoreboard and reports hazards on the decode read addresses ra1/ra2 so decode can stall.
//  Sits between the execute/memory units and the register file.
// PARAMETERS
//  NREQ  3   number of writeback requesters (index 0 = ALU, 1 = load, 2 = multiply)
//  AW    4   register address width
//  DW    32  data width
// PORTS
//  clk          in   1        clock; all state updates on posedge
//  reset        in   1        synchronous, active-high
//  req_valid    in   NREQ     requester i has a write pending
//  req_addr     in   AW*NREQ  destination register of requester i (slice i*AW +: AW)
//  req_data     in   DW*NREQ  write data of requester i (slice i*DW +: DW)
//  req_ready    out  NREQ     one-hot grant; the transfer occurs when req_valid[i] & req_ready[i]
//  we3          out  1        register-file write enable (registered)
//  a3           out  AW       register-file write address (registered)
//  wd3          out  DW       register-file write data (registered)
//  pc_we        out  1        PC write enable; asserted for a granted write to r15 (registered)
//  pc_wd        out  DW       PC write data (registered)
//  sb_set       in   1        issue logic marks sb_set_addr as pending
//  sb_set_addr  in   AW       register being marked pending
//  ra1, ra2     in   AW       decode read addresses
//  busy1, busy2 out  1        the register on ra1/ra2 has a write pending (combinational)
//  sb_err       out  1        sticky flag: sb_set targeted a register that was already pending
// BEHAVIOUR
//  - Reset: we3=0, pc_we=0, a3=0, wd3=0, pc_wd=0, pending=16'h0, sb_err=0, rr_ptr=0.
//    req_ready=0 while reset is high. Reset mid-transfer discards the registered write.
//  - Grant (combinational): at most one req_ready bit is high, and only for a requester whose req_valid is high.
//    With no valid request, req_ready=0.
//  - The register file accepts a write every cycle, so the arbiter never back-pressures once a grant is made.
//  - Latency: handshake in cycle N -> in cycle N+1 either we3=1 with a3/wd3, or pc_we=1 with pc_wd.
//    The write commits at the edge that ends cycle N+1. Throughput is one write per cycle.
//  - Granted addr==15 -> pc_we=1 and we3=0. Any other addr -> we3=1 and pc_we=0. Never both.
//  - we3/pc_we fall to 0 in any cycle after a cycle with no handshake.
//  - Scoreboard: 16-bit vector pending.
//    - sb_set sets pending[sb_set_addr].
//    - A commit (we3 or pc_we high) clears pending[a3], or pending[15] for a PC write.
//    - Set and clear of the same bit in the same cycle -> set wins.
//    - sb_set on a bit that is already set (and not clearing that cycle) -> sb_err=1, sticky until reset.
//  - busyK = pending[raK] & (raK != 15). The r15 read always returns PC+8 and never stalls.
//    No forwarding from the output register: busy stays high through the commit cycle.
//  - Arbitration order is set by CONFIGURATION.
// CONFIGURATION
//  Macro WB_ROUND_ROBIN_EN.
//  - Defined: round-robin. The search starts at rr_ptr. After a grant to i, rr_ptr <= (i+1) mod NREQ.
//    rr_ptr does not change when there is no grant.
//  - Undefined: fixed priority, lowest index wins (ALU > load > multiply). rr_ptr is absent.
// STRUCTURE
//  - Shared header wb_defs.vh holds localparams:
//    REG_PC=4'd15, NREG=16, REQ_ALU=0, REQ_LD=1, REQ_MUL=2.
//  - One sub-module, wb_grant: takes valid[NREQ] (plus ptr when WB_ROUND_ROBIN_EN is defined) and returns a one-hot grant.
//  - Output register, PC steering and scoreboard are in the top level.
// TESTING
//  1. Reset held 2 cycles with all req_valid=1 -> req_ready=0, we3=0, pc_we=0, busy1=0, busy2=0, sb_err=0.
//  2. ALU writes r3=32'hDEADBEEF -> next cycle we3=1, a3=3, wd3=DEADBEEF.
//     sb_set r3 beforehand -> busy1=1 for ra1=3 until the commit edge, then 0.
//  3. Load writes r15=32'h100 -> next cycle pc_we=1, pc_wd=32'h100, we3=0. ra1=15 gives busy1=0 even with pending[15] set.
//  4. All three requesters valid for 6 cycles.
//     - RR defined: grant sequence 0,1,2,0,1,2.
//     - RR undefined: grants 0 every cycle, requesters 1 and 2 starve.
//  5. sb_set r5 twice without a commit in between -> sb_err=1 and it stays 1.
//     sb_set r5 in the same cycle as the commit of r5 -> pending[5] stays 1 and sb_err stays 0.
//  6. Reset asserted in the cycle after a handshake -> no write to r7 ever appears on we3, and pending is cleared.

Source files
------------

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants for the writeback arbiter.
// Register numbering, requester ids, pointer width helper.
package rf_wb_arbiter_pkg;

  localparam logic [3:0] REG_PC = 4'd15;
  localparam int NREG    = 16;
  localparam int REQ_ALU = 0;
  localparam int REQ_LD  = 1;
  localparam int REQ_MUL = 2;

  function automatic int ptr_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback request bus: valid/addr/data from sources, ready back.
// master = requesters, slave = arbiter.
interface rf_wb_arbiter_if #(
  parameter int NREQ = 3,
  parameter int AW   = 4,
  parameter int DW   = 32
) ();

  logic [NREQ-1:0]    req_valid;
  logic [AW*NREQ-1:0] req_addr;
  logic [DW*NREQ-1:0] req_data;
  logic [NREQ-1:0]    req_ready;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/rf_wb_arbiter_grant.sv
// wb_grant: one-hot grant from valid[NREQ].
// Round-robin from ptr when WB_ROUND_ROBIN_EN, else lowest index wins.
module wb_grant
  import rf_wb_arbiter_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int PW   = ptr_w(NREQ)
) (
  input  logic [NREQ-1:0] valid,
`ifdef WB_ROUND_ROBIN_EN
  input  logic [PW-1:0]   ptr,
`endif
  output logic [NREQ-1:0] grant
);

  logic found;
  int   idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
`ifdef WB_ROUND_ROBIN_EN
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
`else
    for (int i = 0; i < NREQ; i++) begin
      if (!found && valid[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
`endif
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the RF write port among NREQ writeback sources, steers r15
// to the PC port, tracks pending writes and flags decode hazards.
// Ports: clk, reset (sync, high), bus (request slave), we3/a3/wd3,
// pc_we/pc_wd, sb_set/sb_set_addr, ra1/ra2, busy1/busy2, sb_err.
// Macro WB_ROUND_ROBIN_EN selects round-robin over fixed priority.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = 4,
  parameter int DW   = 32
) (
  input  logic             clk,
  input  logic             reset,
  rf_wb_arbiter_if.slave   bus,
  output logic             we3,
  output logic [AW-1:0]    a3,
  output logic [DW-1:0]    wd3,
  output logic             pc_we,
  output logic [DW-1:0]    pc_wd,
  input  logic             sb_set,
  input  logic [AW-1:0]    sb_set_addr,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic             busy1,
  output logic             busy2,
  output logic             sb_err
);

  localparam int PW = ptr_w(NREQ);
  localparam logic [AW-1:0] PC_A = AW'(REG_PC);

  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] ready;
  logic [NREQ-1:0] fire;
  logic            hs;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic            we_q;
  logic            pc_we_q;
  logic [NREG-1:0] pending;
  logic [NREG-1:0] clr;
  logic [NREG-1:0] set;

`ifdef WB_ROUND_ROBIN_EN
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] sel_idx;

  wb_grant #(.NREQ(NREQ), .PW(PW)) u_grant (
    .valid (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );
`else
  wb_grant #(.NREQ(NREQ), .PW(PW)) u_grant (
    .valid (bus.req_valid),
    .grant (grant)
  );
`endif

  assign ready         = reset ? '0 : grant;
  assign bus.req_ready = ready;
  assign fire          = bus.req_valid & ready;
  assign hs            = |fire;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
`ifdef WB_ROUND_ROBIN_EN
    sel_idx  = '0;
`endif
    for (int i = 0; i < NREQ; i++) begin
      if (fire[i]) begin
        sel_addr = bus.req_addr[i*AW +: AW];
        sel_data = bus.req_data[i*DW +: DW];
`ifdef WB_ROUND_ROBIN_EN
        sel_idx  = PW'(i);
`endif
      end
    end
  end

  // Reset during the commit cycle kills the write already registered.
  assign we3   = we_q & ~reset;
  assign pc_we = pc_we_q & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q    <= 1'b0;
      pc_we_q <= 1'b0;
      a3      <= '0;
      wd3     <= '0;
      pc_wd   <= '0;
    end else begin
      we_q    <= hs && (sel_addr != PC_A);
      pc_we_q <= hs && (sel_addr == PC_A);
      if (hs && (sel_addr != PC_A)) begin
        a3  <= sel_addr;
        wd3 <= sel_data;
      end
      if (hs && (sel_addr == PC_A)) begin
        pc_wd <= sel_data;
      end
    end
  end

`ifdef WB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (hs) begin
      rr_ptr <= (sel_idx == PW'(NREQ - 1))
                ? '0 : sel_idx + PW'(1);
    end
  end
`endif

  always_comb begin
    clr = '0;
    set = '0;
    if (we3)    clr[a3]     = 1'b1;
    if (pc_we)  clr[REG_PC] = 1'b1;
    if (sb_set) set[sb_set_addr] = 1'b1;
  end

  // Set is ORed in after the clear, so a same-cycle set wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      sb_err  <= 1'b0;
    end else begin
      pending <= (pending & ~clr) | set;
      if (sb_set && pending[sb_set_addr]
          && !clr[sb_set_addr]) begin
        sb_err <= 1'b1;
      end
    end
  end

  // r15 reads come from the PC path and never stall.
  assign busy1 = pending[ra1] & (ra1 != PC_A);
  assign busy2 = pending[ra2] & (ra2 != PC_A);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter.
// Builds with or without WB_ROUND_ROBIN_EN.
module tb_rf_wb_arbiter;
  import rf_wb_arbiter_pkg::*;

  localparam int NREQ = 3;
  localparam int AW   = 4;
  localparam int DW   = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          we3;
  logic [AW-1:0] a3;
  logic [DW-1:0] wd3;
  logic          pc_we;
  logic [DW-1:0] pc_wd;
  logic          sb_set;
  logic [AW-1:0] sb_set_addr;
  logic [AW-1:0] ra1;
  logic [AW-1:0] ra2;
  logic          busy1;
  logic          busy2;
  logic          sb_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  rf_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .we3         (we3),
    .a3          (a3),
    .wd3         (wd3),
    .pc_we       (pc_we),
    .pc_wd       (pc_wd),
    .sb_set      (sb_set),
    .sb_set_addr (sb_set_addr),
    .ra1         (ra1),
    .ra2         (ra2),
    .busy1       (busy1),
    .busy2       (busy2),
    .sb_err      (sb_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    sb_set        = 1'b0;
    sb_set_addr   = '0;
    ra1           = '0;
    ra2           = '0;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] ad,
                         input logic [DW-1:0] d);
    bus.req_valid[i]         = 1'b1;
    bus.req_addr[i*AW +: AW] = ad;
    bus.req_data[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    set_req(REQ_ALU, 4'd3, 32'h1);
    set_req(REQ_LD, 4'd15, 32'h2);
    set_req(REQ_MUL, 4'd4, 32'h3);
    ra1 = 4'd3;
    ra2 = 4'd15;
    repeat (2) begin
      step();
      checks++;
      if (bus.req_ready !== 3'b000) begin
        errors++;
        $display("FAIL rst_ready got %b want 000", bus.req_ready);
      end
      checks++;
      if (we3 !== 1'b0 || pc_we !== 1'b0) begin
        errors++;
        $display("FAIL rst_we got %b/%b want 0/0", we3, pc_we);
      end
      checks++;
      if (busy1 !== 1'b0 || busy2 !== 1'b0) begin
        errors++;
        $display("FAIL rst_busy got %b/%b want 0/0", busy1, busy2);
      end
      checks++;
      if (sb_err !== 1'b0) begin
        errors++;
        $display("FAIL rst_sberr got %b want 0", sb_err);
      end
    end
    idle();
    reset = 1'b0;
    step();
  endtask

  task automatic test_alu_write();
    sb_set      = 1'b1;
    sb_set_addr = 4'd3;
    ra1         = 4'd3;
    step();
    sb_set = 1'b0;
    settle();
    checks++;
    if (busy1 !== 1'b1) begin
      errors++;
      $display("FAIL alu_busy_pre got %b want 1", busy1);
    end
    set_req(REQ_ALU, 4'd3, 32'hDEADBEEF);
    settle();
    checks++;
    if (bus.req_ready !== 3'b001) begin
      errors++;
      $display("FAIL alu_ready got %b want 001", bus.req_ready);
    end
    step();
    bus.req_valid = '0;
    settle();
    checks++;
    if (we3 !== 1'b1 || a3 !== 4'd3 || wd3 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL alu_wr got we=%b a=%0d d=%h want 1 3 deadbeef",
               we3, a3, wd3);
    end
    checks++;
    if (pc_we !== 1'b0) begin
      errors++;
      $display("FAIL alu_pcwe got %b want 0", pc_we);
    end
    checks++;
    if (busy1 !== 1'b1) begin
      errors++;
      $display("FAIL alu_busy_commit got %b want 1", busy1);
    end
    step();
    settle();
    checks++;
    if (we3 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL alu_after got we=%b busy=%b want 0 0", we3, busy1);
    end
  endtask

  task automatic test_pc_write();
    sb_set      = 1'b1;
    sb_set_addr = 4'd15;
    step();
    sb_set = 1'b0;
    ra1    = 4'd15;
    settle();
    checks++;
    if (busy1 !== 1'b0) begin
      errors++;
      $display("FAIL pc_busy got %b want 0", busy1);
    end
    set_req(REQ_LD, 4'd15, 32'h100);
    settle();
    checks++;
    if (bus.req_ready !== 3'b010) begin
      errors++;
      $display("FAIL pc_ready got %b want 010", bus.req_ready);
    end
    step();
    bus.req_valid = '0;
    settle();
    checks++;
    if (pc_we !== 1'b1 || pc_wd !== 32'h100 || we3 !== 1'b0) begin
      errors++;
      $display("FAIL pc_wr got pcwe=%b pcwd=%h we3=%b want 1 100 0",
               pc_we, pc_wd, we3);
    end
    step();
    settle();
    checks++;
    if (pc_we !== 1'b0) begin
      errors++;
      $display("FAIL pc_after got %b want 0", pc_we);
    end
  endtask

  task automatic test_arbitration();
    logic [NREQ-1:0] exp;
    logic [AW-1:0]   ea;
    logic [DW-1:0]   ed;
    do_reset();
    idle();
    set_req(REQ_ALU, 4'd1, 32'hA0);
    set_req(REQ_LD, 4'd2, 32'hA1);
    set_req(REQ_MUL, 4'd4, 32'hA2);
    for (int c = 0; c < 6; c++) begin
      settle();
`ifdef WB_ROUND_ROBIN_EN
      exp = 3'b001 << (c % 3);
`else
      exp = 3'b001;
`endif
      ea = (exp == 3'b001) ? 4'd1 : (exp == 3'b010) ? 4'd2 : 4'd4;
      ed = (exp == 3'b001) ? 32'hA0 :
           (exp == 3'b010) ? 32'hA1 : 32'hA2;
      checks++;
      if (bus.req_ready !== exp) begin
        errors++;
        $display("FAIL arb_grant%0d got %b want %b",
                 c, bus.req_ready, exp);
      end
      step();
      checks++;
      if (we3 !== 1'b1 || a3 !== ea || wd3 !== ed) begin
        errors++;
        $display("FAIL arb_wr%0d got we=%b a=%0d d=%h want 1 %0d %h",
                 c, we3, a3, wd3, ea, ed);
      end
    end
    idle();
    step();
  endtask

  task automatic test_scoreboard();
    do_reset();
    idle();
    sb_set      = 1'b1;
    sb_set_addr = 4'd5;
    step();
    step();
    sb_set = 1'b0;
    settle();
    checks++;
    if (sb_err !== 1'b1) begin
      errors++;
      $display("FAIL sb_err_set got %b want 1", sb_err);
    end
    step();
    step();
    checks++;
    if (sb_err !== 1'b1) begin
      errors++;
      $display("FAIL sb_err_sticky got %b want 1", sb_err);
    end
    do_reset();
    settle();
    checks++;
    if (sb_err !== 1'b0) begin
      errors++;
      $display("FAIL sb_err_rst got %b want 0", sb_err);
    end
    sb_set      = 1'b1;
    sb_set_addr = 4'd5;
    step();
    sb_set = 1'b0;
    set_req(REQ_ALU, 4'd5, 32'h55);
    step();
    bus.req_valid = '0;
    sb_set        = 1'b1;
    sb_set_addr   = 4'd5;
    settle();
    checks++;
    if (we3 !== 1'b1 || a3 !== 4'd5) begin
      errors++;
      $display("FAIL sb_commit got we=%b a=%0d want 1 5", we3, a3);
    end
    step();
    sb_set = 1'b0;
    ra1    = 4'd5;
    settle();
    checks++;
    if (busy1 !== 1'b1 || sb_err !== 1'b0) begin
      errors++;
      $display("FAIL sb_setwins got busy=%b err=%b want 1 0",
               busy1, sb_err);
    end
    step();
    checks++;
    if (busy1 !== 1'b1) begin
      errors++;
      $display("FAIL sb_hold got %b want 1", busy1);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    idle();
    sb_set      = 1'b1;
    sb_set_addr = 4'd7;
    step();
    sb_set = 1'b0;
    set_req(REQ_ALU, 4'd7, 32'h77);
    step();
    bus.req_valid = '0;
    reset         = 1'b1;
    settle();
    checks++;
    if (we3 !== 1'b0 || pc_we !== 1'b0) begin
      errors++;
      $display("FAIL mid_we got %b/%b want 0/0", we3, pc_we);
    end
    step();
    reset = 1'b0;
    ra1   = 4'd7;
    settle();
    checks++;
    if (we3 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL mid_after got we=%b busy=%b want 0 0", we3, busy1);
    end
    step();
    checks++;
    if (we3 !== 1'b0) begin
      errors++;
      $display("FAIL mid_late got %b want 0", we3);
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_alu_write();
    test_pc_write();
    test_arbitration();
    test_scoreboard();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
